// File: rtl/memory_pkg.sv
// rtl/memory_pkg.sv - shared types and constants for the wait-stated memory regions
package memory_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } mem_state_t;

  localparam logic [15:0] VACANT_READ = 16'h3FFF;

  localparam logic [15:0] FRAM_START = 16'h4400;
  localparam logic [15:0] RAM_START  = 16'h1C00;
  localparam logic [15:0] INFO_START = 16'h1800;

  // Inclusive window test; an empty window (hi < lo) never matches.
  function automatic logic in_window(input logic [15:0] a, input logic [15:0] lo,
                                     input logic [15:0] hi);
    return (a >= lo) && (a <= hi);
  endfunction

endpackage

// File: rtl/mem_byte_array.sv
// rtl/mem_byte_array.sv - word-organised byte storage with independent low/high lane enables
module mem_byte_array
  import memory_pkg::*;
#(
  parameter int         DEPTH          = 1024,
  parameter logic [7:0] INITVAL        = 8'h00,
  parameter bit         CLEAR_ON_RESET = 1'b0,
  parameter int         AW             = 9
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] idx,
  input  logic          we_lo,
  input  logic          we_hi,
  input  logic [15:0]   wdata,
  output logic [15:0]   rdata
);

  logic [7:0] lane_lo [DEPTH/2];
  logic [7:0] lane_hi [DEPTH/2];

  // Reset beats any write in the same cycle; contents survive reset unless cleared.
  always_ff @(posedge clk) begin
    if (reset) begin
      if (CLEAR_ON_RESET) begin
        for (int i = 0; i < DEPTH/2; i++) begin
          lane_lo[i] <= INITVAL;
          lane_hi[i] <= INITVAL;
        end
      end
    end else begin
      if (we_lo) lane_lo[idx] <= wdata[7:0];
      if (we_hi) lane_hi[idx] <= wdata[15:8];
    end
  end

  assign rdata = {lane_hi[idx], lane_lo[idx]};

endmodule

// File: rtl/memory_ws.sv
// rtl/memory_ws.sv - MAB/MDB memory region with wait-state FSM, write protect and vacant reads
module memory_ws
  import memory_pkg::*;
#(
  parameter logic [15:0] START          = FRAM_START,
  parameter int          DEPTH          = 1024,
  parameter logic [7:0]  INITVAL        = 8'h00,
  parameter int          WAIT_STATES    = 0,
  parameter bit          CLEAR_ON_RESET = 1'b0,
  parameter logic [15:0] WP_START       = START,
  parameter logic [15:0] WP_END         = START - 16'd1
) (
  input  logic        MCLK,
  input  logic        reset,
  input  logic        MREQ,
  input  logic [15:0] MAB,
  input  logic [15:0] MDBwrite,
  input  logic        MW,
  input  logic        BW,
  input  logic        WPROT,
  output logic [15:0] MDBread,
  output logic        MRDY,
  output logic        VIOL
);

  localparam int          AW    = (DEPTH > 2) ? $clog2(DEPTH/2) : 1;
  localparam logic [16:0] END_X = 17'(START) + 17'(DEPTH);

  mem_state_t    state, state_n;
  logic [2:0]    cnt, cnt_n;
  logic          do_access;

  logic [15:0]   addr, hi_addr;
  logic          in_range, prot, reject;
  logic [AW-1:0] idx;
  logic          we_lo, we_hi;
  logic [15:0]   wdata, rdata, rd_val;

  // Word accesses are aligned down before the range and protection checks.
  assign addr     = BW ? MAB : {MAB[15:1], 1'b0};
  assign hi_addr  = {addr[15:1], 1'b1};
  assign in_range = ({1'b0, addr} >= {1'b0, START}) && ({1'b0, addr} < END_X);
  assign prot     = WPROT && MW &&
                    (in_window(addr, WP_START, WP_END) ||
                     (!BW && in_window(hi_addr, WP_START, WP_END)));
  assign reject   = !in_range || prot;
  assign idx      = AW'((addr - START) >> 1);

  assign we_lo = do_access && MW && !reject && (!BW || !addr[0]);
  assign we_hi = do_access && MW && !reject && (!BW || addr[0]);
  assign wdata = BW ? {MDBwrite[7:0], MDBwrite[7:0]} : MDBwrite;

  mem_byte_array #(
    .DEPTH          (DEPTH),
    .INITVAL        (INITVAL),
    .CLEAR_ON_RESET (CLEAR_ON_RESET),
    .AW             (AW)
  ) u_array (
    .clk   (MCLK),
    .reset (reset),
    .idx   (idx),
    .we_lo (we_lo),
    .we_hi (we_hi),
    .wdata (wdata),
    .rdata (rdata)
  );

  assign rd_val = BW ? {8'h00, (addr[0] ? rdata[15:8] : rdata[7:0])} : rdata;

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    do_access = 1'b0;
    case (state)
      S_IDLE: begin
        if (MREQ) begin
          state_n = S_WAIT;
          cnt_n   = 3'(WAIT_STATES);
        end
      end
      S_WAIT: begin
        if (cnt != 3'd0) begin
          cnt_n = cnt - 3'd1;
        end else begin
          do_access = 1'b1;
          state_n   = S_RESP;
        end
      end
      S_RESP: begin
        if (MREQ) begin
          state_n = S_WAIT;
          cnt_n   = 3'(WAIT_STATES);
        end else begin
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // MRDY/VIOL are raised at the access edge so they sit high for the RESP cycle.
  always_ff @(posedge MCLK) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= 3'd0;
      MDBread <= 16'h0000;
      MRDY    <= 1'b0;
      VIOL    <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      MRDY  <= do_access;
      VIOL  <= do_access && reject;
      if (do_access && !MW) MDBread <= in_range ? rd_val : VACANT_READ;
    end
  end

endmodule

// File: tb/tb_memory_ws.sv
// tb/tb_memory_ws.sv - directed scoreboard bench for memory_ws (FRAM-style and RAM-style regions)
module tb_memory_ws;
  import memory_pkg::*;

  typedef struct {
    string       tag;
    logic [15:0] data;
    logic        viol;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_reset, a_mreq, a_mw, a_bw, a_wprot, a_mrdy, a_viol;
  logic [15:0] a_mab, a_wd, a_rd;
  logic        b_reset, b_mreq, b_mw, b_bw, b_wprot, b_mrdy, b_viol;
  logic [15:0] b_mab, b_wd, b_rd;

  int   n_assert = 0;
  int   n_fail   = 0;
  exp_t sb[$];

  memory_ws #(
    .START (16'h4400), .DEPTH (1024), .INITVAL (8'h00), .WAIT_STATES (2),
    .CLEAR_ON_RESET (1'b0), .WP_START (16'h4400), .WP_END (16'h44FF)
  ) dut_a (
    .MCLK (clk), .reset (a_reset), .MREQ (a_mreq), .MAB (a_mab), .MDBwrite (a_wd),
    .MW (a_mw), .BW (a_bw), .WPROT (a_wprot), .MDBread (a_rd), .MRDY (a_mrdy), .VIOL (a_viol)
  );

  memory_ws #(
    .START (16'h1C00), .DEPTH (16), .INITVAL (8'hA5), .WAIT_STATES (0),
    .CLEAR_ON_RESET (1'b1)
  ) dut_b (
    .MCLK (clk), .reset (b_reset), .MREQ (b_mreq), .MAB (b_mab), .MDBwrite (b_wd),
    .MW (b_mw), .BW (b_bw), .WPROT (b_wprot), .MDBread (b_rd), .MRDY (b_mrdy), .VIOL (b_viol)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input int d, input logic mreq, input logic mw, input logic bw,
                       input logic wprot, input logic [15:0] addr, input logic [15:0] wd);
    if (d == 0) begin
      a_mreq = mreq; a_mw = mw; a_bw = bw; a_wprot = wprot; a_mab = addr; a_wd = wd;
    end else begin
      b_mreq = mreq; b_mw = mw; b_bw = bw; b_wprot = wprot; b_mab = addr; b_wd = wd;
    end
  endtask

  task automatic drop_req(input int d);
    if (d == 0) a_mreq = 1'b0;
    else        b_mreq = 1'b0;
  endtask

  function automatic logic get_mrdy(input int d);
    return (d == 0) ? a_mrdy : b_mrdy;
  endfunction

  function automatic logic get_viol(input int d);
    return (d == 0) ? a_viol : b_viol;
  endfunction

  function automatic logic [15:0] get_rd(input int d);
    return (d == 0) ? a_rd : b_rd;
  endfunction

  // Waits for MRDY (bounded), pops the scoreboard and checks data, VIOL and edge count.
  task automatic wait_and_check(input int d);
    int   n;
    logic got;
    exp_t e;
    n   = 0;
    got = 1'b0;
    while (!got && n < 20) begin
      @(posedge clk);
      #1;
      n++;
      got = get_mrdy(d);
    end
    e = sb.pop_front();
    chk({e.tag, ":mrdy"}, 16'(got), 16'h0001);
    chk({e.tag, ":data"}, get_rd(d), e.data);
    chk({e.tag, ":viol"}, 16'(get_viol(d)), 16'(e.viol));
    chk({e.tag, ":edges"}, 16'(n), 16'(e.lat));
  endtask

  task automatic access(input int d, input string tag, input logic mw, input logic bw,
                        input logic wprot, input logic [15:0] addr, input logic [15:0] wd,
                        input logic [15:0] exp_data, input logic exp_viol);
    int ws;
    ws = (d == 0) ? 2 : 0;
    @(negedge clk);
    drive(d, 1'b1, mw, bw, wprot, addr, wd);
    sb.push_back('{tag, exp_data, exp_viol, ws + 2});
    wait_and_check(d);
    drop_req(d);
    @(posedge clk);
    #1;
    chk({tag, ":pulse"}, 16'(get_mrdy(d)), 16'h0000);
    chk({tag, ":violpulse"}, 16'(get_viol(d)), 16'h0000);
  endtask

  logic [15:0] b2b_addr [4];
  logic [15:0] b2b_data [4];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    a_reset = 1'b1; b_reset = 1'b1;
    drive(0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    drive(1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    repeat (3) @(posedge clk);
    #1;
    chk("a_reset:rd", a_rd, 16'h0000);
    chk("a_reset:mrdy", 16'(a_mrdy), 16'h0000);
    chk("a_reset:viol", 16'(a_viol), 16'h0000);
    chk("a_reset:state", 16'(dut_a.state), 16'(S_IDLE));
    chk("b_reset:rd", b_rd, 16'h0000);
    @(negedge clk);
    a_reset = 1'b0; b_reset = 1'b0;

    // FRAM-style region, 2 wait states, protected window 4400..44FF
    access(0, "w4400",    1, 0, 0, 16'h4400, 16'h1234, 16'h0000, 0);
    access(0, "r4400",    0, 0, 0, 16'h4400, 16'h0000, 16'h1234, 0);
    access(0, "w4402",    1, 0, 0, 16'h4402, 16'h0000, 16'h1234, 0);
    access(0, "wb4403",   1, 1, 0, 16'h4403, 16'h00AB, 16'h1234, 0);
    access(0, "r4403",    0, 0, 0, 16'h4403, 16'h0000, 16'hAB00, 0);
    access(0, "rb4401",   0, 1, 0, 16'h4401, 16'h0000, 16'h0012, 0);
    access(0, "r1c00",    0, 0, 0, 16'h1C00, 16'h0000, 16'h3FFF, 1);
    access(0, "w1c00",    1, 0, 0, 16'h1C00, 16'h9999, 16'h3FFF, 1);
    access(0, "wp_w4400", 1, 0, 1, 16'h4400, 16'hFFFF, 16'h3FFF, 1);
    access(0, "wp_r4400", 0, 0, 1, 16'h4400, 16'h0000, 16'h1234, 0);
    access(0, "np_w4400", 1, 0, 0, 16'h4400, 16'hFFFF, 16'h1234, 0);
    access(0, "np_r4400", 0, 0, 0, 16'h4400, 16'h0000, 16'hFFFF, 0);
    access(0, "w47ff",    1, 0, 0, 16'h47FF, 16'hBEEF, 16'hFFFF, 0);
    access(0, "r47fe",    0, 0, 0, 16'h47FE, 16'h0000, 16'hBEEF, 0);
    access(0, "rb4800",   0, 1, 0, 16'h4800, 16'h0000, 16'h3FFF, 1);
    access(0, "wb4500",   1, 1, 1, 16'h4500, 16'h0077, 16'h3FFF, 0);
    access(0, "rb4500",   0, 1, 0, 16'h4500, 16'h0000, 16'h0077, 0);
    access(0, "wp_w44ff", 1, 0, 1, 16'h44FF, 16'h1111, 16'h0077, 1);
    access(0, "w4406",    1, 0, 0, 16'h4406, 16'h0BAD, 16'h0077, 0);

    // reset lands while the write is still counting wait states
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h4406, 16'h5555);
    @(posedge clk);
    @(negedge clk);
    a_reset = 1'b1;
    a_mreq  = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst:mrdy", 16'(a_mrdy), 16'h0000);
    chk("midrst:state", 16'(dut_a.state), 16'(S_IDLE));
    chk("midrst:rd", a_rd, 16'h0000);
    @(negedge clk);
    a_reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      chk("midrst:quiet", 16'(a_mrdy), 16'h0000);
    end
    access(0, "r4406",    0, 0, 0, 16'h4406, 16'h0000, 16'h0BAD, 0);
    access(0, "retained", 0, 0, 0, 16'h4400, 16'h0000, 16'hFFFF, 0);

    // RAM-style region, no wait states, cleared to A5 on reset, no protected window
    access(1, "b_rb1c00", 0, 1, 0, 16'h1C00, 16'h0000, 16'h00A5, 0);
    access(1, "b_r1c0e",  0, 0, 0, 16'h1C0E, 16'h0000, 16'hA5A5, 0);
    access(1, "b_w1c02",  1, 0, 1, 16'h1C02, 16'h1357, 16'hA5A5, 0);
    access(1, "b_w1c04",  1, 0, 1, 16'h1C04, 16'h2468, 16'hA5A5, 0);
    access(1, "b_rb1c10", 0, 1, 0, 16'h1C10, 16'h0000, 16'h3FFF, 1);

    b2b_addr[0] = 16'h1C02; b2b_data[0] = 16'h1357;
    b2b_addr[1] = 16'h1C04; b2b_data[1] = 16'h2468;
    b2b_addr[2] = 16'h1C00; b2b_data[2] = 16'hA5A5;
    b2b_addr[3] = 16'h1C03; b2b_data[3] = 16'h1357;
    @(negedge clk);
    drive(1, 1'b1, 1'b0, 1'b0, 1'b0, b2b_addr[0], 16'h0000);
    for (int i = 0; i < 4; i++) sb.push_back('{$sformatf("b2b%0d", i), b2b_data[i], 1'b0, 2});
    for (int i = 0; i < 4; i++) begin
      wait_and_check(1);
      if (i < 3) drive(1, 1'b1, 1'b0, 1'b0, 1'b0, b2b_addr[i+1], 16'h0000);
      else       drop_req(1);
    end

    @(negedge clk);
    b_reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    b_reset = 1'b0;
    access(1, "b_clr1c02", 0, 0, 0, 16'h1C02, 16'h0000, 16'hA5A5, 0);
    access(1, "b_clr1c04", 0, 0, 0, 16'h1C04, 16'h0000, 16'hA5A5, 0);

    chk("sb_empty", 16'(sb.size()), 16'h0000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/memory_ws.md
# memory_ws

Parametrised successor to the single-cycle memory model. A byte-addressed memory region on the MSP430 memory bus (MAB/MDB) with a configurable wait-state FSM and a ready handshake, as needed for FRAM above 8 MHz. Also provides a write-protected sub-window, vacant-memory read value, and an access-violation pulse. One instance per region (FRAM, RAM, info) sits behind the memory-map decoder.

## Interface
Parameters:
- START, 16'h4400, first byte address of region
- DEPTH, 1024, region size in bytes (even, ≥2)
- INITVAL, 8'h00, byte value loaded at reset when CLEAR_ON_RESET=1
- WAIT_STATES, 0, extra cycles per access (0..7)
- CLEAR_ON_RESET, 0, 1 = reset rewrites every byte to INITVAL (RAM); 0 = contents retained (FRAM)
- WP_START, START, first byte of write-protected window
- WP_END, START-1, last byte of window (WP_END<WP_START = no window)

Ports:
- MCLK  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- MREQ  in  1  access request; MAB/MDBwrite/MW/BW held stable until MRDY
- MAB  in  16  byte address
- MDBwrite  in  16  write data
- MW  in  1  1 = write, 0 = read
- BW  in  1  1 = byte access, 0 = word
- WPROT  in  1  1 = enforce write-protect window
- MDBread  out  16  registered read data
- MRDY  out  1  one-cycle completion pulse
- VIOL  out  1  one-cycle pulse with MRDY on a rejected access

## Operation
- In-range: START ≤ MAB < START+DEPTH. Word accesses force MAB[0]=0 (4405 → 4404).
- Word read: MDBread = {mem[a+1], mem[a]}. Byte read: MDBread = {8'h00, mem[MAB]}.
- Word write: mem[a] ← MDBwrite[7:0], mem[a+1] ← MDBwrite[15:8]. Byte write: mem[MAB] ← MDBwrite[7:0].
- Out-of-range read: MDBread = 16'h3FFF, VIOL=1. Out-of-range write: no change, VIOL=1.
- Protected write: WPROT=1 and any written byte in [WP_START, WP_END]; whole access dropped, VIOL=1. Reads are never protected.
- Writes leave MDBread at its previous value.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: MREQ=1 → WAIT, cnt←WAIT_STATES.
  - WAIT: cnt≠0 → cnt−1. cnt=0 → perform access at this edge, go to RESP.
  - RESP: MRDY=1 (VIOL if rejected). MREQ=1 here starts the next access as in IDLE; otherwise → IDLE.
- Request fields are sampled at the access edge, not at the request edge; the master must hold them stable.

## Timing
- Reset values: MDBread=0, MRDY=0, VIOL=0, state IDLE, cnt=0. Memory is reset to INITVAL only if CLEAR_ON_RESET=1.
- Latency: MREQ sampled at edge k → access at edge k+1+WAIT_STATES → MRDY high from that edge for one cycle.
  - WAIT_STATES=0: 2 cycles per access (IDLE→WAIT→RESP).
  - Back-to-back through RESP: WAIT_STATES+2 cycles per access.
- MREQ dropped during WAIT: the access still completes (no abort).
- Reset mid-access: FSM → IDLE, the pending write is not performed, no MRDY.
- Reset has priority over any access in the same cycle.
- Word access at START+DEPTH−1 is aligned down and is in range. Byte access at START+DEPTH is out of range.

## Structure
- Shared package memory_pkg:
  - FSM state enum
  - VACANT_READ = 16'h3FFF
  - region base constants (FRAM_START, RAM_START, INFO_START)
- Sub-module mem_byte_array:
  - DEPTH×8 storage, two byte lanes with independent write enables
  - reset-to-INITVAL option
- memory_ws contains the decode, protection check and wait-state FSM.

## Test plan
- WAIT_STATES=2: write word 16'h1234 to 4400, then read word 4400 → MRDY 4 edges after each request, MDBread=16'h1234, VIOL=0.
- Byte write 16'h00AB to 4403, then word read 4403 → MDBread=16'hAB00 (lanes correct, address aligned to 4402). Byte read 4401 → 16'h0012.
- Read 1C00 (out of range) → MDBread=16'h3FFF, VIOL=1 with MRDY. Write 1C00 → no array change, VIOL=1.
- WP window 4400..44FF:
  - WPROT=1, write 16'hFFFF to 4400 → VIOL=1, m[4400] stays 16'h1234.
  - WPROT=0, same write → written, VIOL=0.
- reset asserted in WAIT during a write of 16'h5555 to 4406 → no MRDY, location unchanged, FSM in IDLE.
- After reset: CLEAR_ON_RESET=1 with INITVAL=8'hA5 → all bytes 8'hA5; CLEAR_ON_RESET=0 → contents retained.
- Back-to-back reads with MREQ held, WAIT_STATES=0 → MRDY every 2 cycles, correct data each time.
